image_window_compositor: RTL

- Parametrised multi-window image painter for the VGA pixel pipeline.
- Decodes the current scan position (cur_x, cur_y) into one of NUM_WIN side-by-side image windows.
- Generates the read address for that window's image ROM and emits a registered output pixel.
- Sits between the VGA sync counter and the colour DAC. Adds what a single fixed painter lacks: N windows, integer pixel-replication scaling, per-window enable, and a programmable background.

---
 rtl/image_window_compositor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/image_window_compositor.sv
`default_nettype none
// ============================================================================
// Module   : image_window_compositor
// Brief    : Decodes the VGA scan position into one of NUM_WIN side-by-side
//            image windows, addresses each window's ROM and outputs a pixel.
// Revision : 1.0
// ============================================================================
module image_window_compositor #(
    parameter int              NUM_WIN    = 2,
    parameter int              IMG_W      = 32,
    parameter int              IMG_H      = 32,
    parameter int              SCALE_LOG2 = 0,
    parameter int              X0         = 1,
    parameter int              Y0         = 1,
    parameter int              GAP        = 3,
    parameter int              BASE_ADDR  = 40,
    parameter int              ADDR_W     = 19,
    parameter int              PIX_W      = 8,
    parameter logic [PIX_W-1:0] BG_PIXEL  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  cur_x,
    input  logic [9:0]                  cur_y,
    input  logic [NUM_WIN-1:0]          win_en,
    output logic [NUM_WIN*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_WIN*PIX_W-1:0]    rd_data,
    output logic [PIX_W-1:0]            pix_out,
    output logic                        pix_active
);

    localparam int c_S      = 1 << SCALE_LOG2;
    localparam int c_WW     = IMG_W * c_S;
    localparam int c_WH     = IMG_H * c_S;
    localparam int c_PITCH  = c_WW + GAP;
    localparam int c_X_LAST = X0 + (NUM_WIN - 1) * c_PITCH + c_WW - 1;
    localparam int c_Y_LAST = Y0 + c_WH - 1;
    localparam int c_SEL_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [9:0]        c_Y0   = 10'(Y0);
    localparam logic [9:0]        c_YE   = 10'(c_Y_LAST);

    generate
        if (NUM_WIN < 1 || NUM_WIN > 4 || SCALE_LOG2 < 0 || SCALE_LOG2 > 2 ||
            c_X_LAST > 1023 || c_Y_LAST > 1023) begin : g_bad_cfg
            $error("image_window_compositor: window geometry does not fit the 1024x1024 scan space");
        end
    endgenerate

    // Row term is common to every window since they share one vertical band.
    logic                          w_row_hit;
    logic [9:0]                    w_dy;
    logic [ADDR_W-1:0]             w_row_base;

    assign w_row_hit  = (cur_y >= c_Y0) && (cur_y <= c_YE);
    assign w_dy       = cur_y - c_Y0;
    // IMG_W is a constant, so this product reduces to shifts and adds.
    assign w_row_base = c_BASE + ADDR_W'(w_dy >> SCALE_LOG2) * ADDR_W'(IMG_W);

    logic [NUM_WIN-1:0]               w_hit;
    logic [NUM_WIN-1:0][ADDR_W-1:0]   w_addr;

    generate
        for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
            localparam logic [9:0] c_XS = 10'(X0 + k * c_PITCH);
            localparam logic [9:0] c_XE = 10'(X0 + k * c_PITCH + c_WW - 1);

            logic [9:0] w_dx;

            assign w_dx      = cur_x - c_XS;
            assign w_hit[k]  = w_row_hit && (cur_x >= c_XS) && (cur_x <= c_XE) && win_en[k];
            assign w_addr[k] = w_row_base + ADDR_W'(w_dx >> SCALE_LOG2);
        end
    endgenerate

    // Windows are disjoint, so at most one hit bit is set: OR-encoding suffices.
    logic [c_SEL_W-1:0] w_sel;
    logic               w_hit_any;

    always_comb begin
        w_sel     = '0;
        w_hit_any = |w_hit;
        for (int k = 0; k < NUM_WIN; k++) begin
            if (w_hit[k]) begin
                w_sel = w_sel | c_SEL_W'(k);
            end
        end
    end

    logic [NUM_WIN-1:0][ADDR_W-1:0]   r_addr;
    logic [c_SEL_W-1:0]               r_sel;
    logic                             r_hit_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= {NUM_WIN{c_BASE}};
            r_sel     <= '0;
            r_hit_any <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WIN; k++) begin
                r_addr[k] <= w_hit[k] ? w_addr[k] : c_BASE;
            end
            r_sel     <= w_sel;
            r_hit_any <= w_hit_any;
        end
    end

    assign rd_addr = r_addr;

    logic [NUM_WIN-1:0][PIX_W-1:0]    w_data;
    logic [PIX_W-1:0]                 w_pix;

    assign w_data = rd_data;

    always_comb begin
        w_pix = '0;
        for (int k = 0; k < NUM_WIN; k++) begin
            if (r_sel == c_SEL_W'(k)) begin
                w_pix = w_pix | w_data[k];
            end
        end
    end

    logic [PIX_W-1:0] r_pix;
    logic             r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix    <= BG_PIXEL;
            r_active <= 1'b0;
        end else if (r_hit_any) begin
            r_pix    <= w_pix;
            r_active <= 1'b1;
        end else begin
            r_pix    <= BG_PIXEL;
            r_active <= 1'b0;
        end
    end

    assign pix_out    = r_pix;
    assign pix_active = r_active;

endmodule
`default_nettype wire
